explored_lookup: RTL and testbench

//  Pipelined linear-scan search engine over the explored-set RAM (sync-read, one

---
 rtl/explored_lookup.sv | 169 ++++++++++++++++
 tb/tb_explored_lookup.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/explored_lookup.sv
// Pipelined linear-scan search over the sync-read explored-set RAM; EXPLORED_LOOKUP_PROBES_EN adds a probe counter.
// Issues one read per clock, flushes in-flight reads on a hit or end-of-list, and never stalls once started.
module explored_lookup #(
  parameter int MAX_NODES  = 100,
  parameter int ADDR_W     = 7,
  parameter int REC_W      = 272,
  parameter int KEY_W      = 16,
  parameter int ID_LSB     = 224,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              find,
  input  logic              abort,
  input  logic [KEY_W-1:0]  key,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [REC_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] result_addr,
  output logic [REC_W-1:0]  result_node
`ifdef EXPLORED_LOOKUP_PROBES_EN
  ,
  output logic [ADDR_W:0]   probes
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_NODES - 1);

  state_t                           state_q, state_d;
  logic [ADDR_W-1:0]                rd_addr_q, rd_addr_d;
  logic [KEY_W-1:0]                 key_q, key_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             found_q, found_d;
  logic [ADDR_W-1:0]                res_addr_q, res_addr_d;
  logic [REC_W-1:0]                 res_node_q, res_node_d;
  logic [RD_LATENCY-1:0]            tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0][ADDR_W-1:0] tag_addr_q, tag_addr_d;
`ifdef EXPLORED_LOOKUP_PROBES_EN
  logic [ADDR_W:0]                  probes_q, probes_d;
`endif

  logic [KEY_W-1:0] rd_id;
  logic             cmp_vld;
  logic             hit;
  logic             stop;

  assign rd_id   = rd_data[ID_LSB +: KEY_W];
  assign cmp_vld = tag_vld_q[RD_LATENCY-1];
  assign hit     = cmp_vld && (rd_id == key_q);
  // An empty slot ends the list; with key 0 it is also the hit itself.
  assign stop    = cmp_vld && ((rd_id == key_q) || (rd_id == '0));

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    key_d      = key_q;
    found_d    = found_q;
    res_addr_d = res_addr_q;
    res_node_d = res_node_q;
`ifdef EXPLORED_LOOKUP_PROBES_EN
    probes_d   = probes_q;
`endif
    tag_vld_d     = '0;
    tag_addr_d    = '0;
    tag_vld_d[0]  = (state_q == S_SCAN);
    tag_addr_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (find && !abort) begin
          key_d      = key;
          found_d    = 1'b0;
          res_addr_d = '0;
          res_node_d = '0;
          rd_addr_d  = '0;
`ifdef EXPLORED_LOOKUP_PROBES_EN
          probes_d   = '0;
`endif
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                        rd_addr_d = rd_addr_q + 1'b1;
      end
      S_DRAIN: begin
        if (tag_vld_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef EXPLORED_LOOKUP_PROBES_EN
    if (cmp_vld) probes_d = probes_q + 1'b1;
`endif
    // First stop in address order wins; younger reads still in the pipe are dropped.
    if (stop) begin
      found_d    = hit;
      res_addr_d = tag_addr_q[RD_LATENCY-1];
      res_node_d = hit ? rd_data : '0;
      tag_vld_d  = '0;
      state_d    = S_DONE;
    end

    if (abort && busy_q) begin
      state_d    = S_IDLE;
      tag_vld_d  = '0;
      found_d    = 1'b0;
      res_addr_d = '0;
      res_node_d = '0;
`ifdef EXPLORED_LOOKUP_PROBES_EN
      probes_d   = '0;
`endif
    end

    busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      key_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      res_addr_q <= '0;
      res_node_q <= '0;
      tag_vld_q  <= '0;
      tag_addr_q <= '0;
`ifdef EXPLORED_LOOKUP_PROBES_EN
      probes_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      res_addr_q <= res_addr_d;
      res_node_q <= res_node_d;
      tag_vld_q  <= tag_vld_d;
      tag_addr_q <= tag_addr_d;
`ifdef EXPLORED_LOOKUP_PROBES_EN
      probes_q   <= probes_d;
`endif
    end
  end

  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign result_addr = res_addr_q;
  assign result_node = res_node_q;
`ifdef EXPLORED_LOOKUP_PROBES_EN
  assign probes      = probes_q;
`endif

endmodule

// File: tb/tb_explored_lookup.sv
// Scoreboard bench for explored_lookup: two instances (read latency 1 and 3) with behavioural RAMs.
module tb_explored_lookup;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    logic          found;
    logic [6:0]    addr;
    logic [271:0]  node;
    int            probes;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  logic          find1 = 1'b0, abort1 = 1'b0, find3 = 1'b0, abort3 = 1'b0;
  logic [15:0]   key1 = '0, key3 = '0;
  logic [6:0]    rd_addr1, rd_addr3, result_addr1, result_addr3;
  logic [271:0]  rd_data1, rd_data3, result_node1, result_node3, p3a, p3b;
  logic          busy1, done1, found1, busy3, done3, found3;
  logic [271:0]  ram1 [0:99];
  logic [271:0]  ram3 [0:99];
  int            max1 = 0;
`ifdef EXPLORED_LOOKUP_PROBES_EN
  logic [7:0]    probes1, probes3;
`endif

  explored_lookup #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst), .find(find1), .abort(abort1), .key(key1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1), .done(done1),
    .found(found1), .result_addr(result_addr1), .result_node(result_node1)
`ifdef EXPLORED_LOOKUP_PROBES_EN
    , .probes(probes1)
`endif
  );

  explored_lookup #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst), .find(find3), .abort(abort3), .key(key3),
    .rd_addr(rd_addr3), .rd_data(rd_data3), .busy(busy3), .done(done3),
    .found(found3), .result_addr(result_addr3), .result_node(result_node3)
`ifdef EXPLORED_LOOKUP_PROBES_EN
    , .probes(probes3)
`endif
  );

  // Sync-read RAM models: one register stage for latency 1, three for latency 3.
  always @(posedge clk) begin
    rd_data1 <= ram1[rd_addr1];
    p3a      <= ram3[rd_addr3];
    p3b      <= p3a;
    rd_data3 <= p3b;
  end

  function automatic logic [271:0] mkrec(input logic [15:0] id, input int addr);
    logic [271:0] r;
    r = '0;
    if (id != 16'd0) begin
      r[224 +: 16] = id;
      r[271:256]   = ~id;
      r[31:0]      = 32'hA500_0000 | addr;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rd_addr1 >= 7'd100 || rd_addr3 >= 7'd100) begin
      errors++;
      $display("FAIL rd_addr_range actual=%0d/%0d required<100", rd_addr1, rd_addr3);
    end
    if (int'(rd_addr1) > max1) max1 = int'(rd_addr1);
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done cycle=%0d required=no_done", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1_done_cycle", 272'(cyc), 272'(e1.cyc));
        check("dut1_busy_at_done", 272'(busy1), 272'(0));
        check("dut1_found", 272'(found1), 272'(e1.found));
        check("dut1_result_addr", 272'(result_addr1), 272'(e1.addr));
        check("dut1_result_node", result_node1, e1.node);
`ifdef EXPLORED_LOOKUP_PROBES_EN
        check("dut1_probes", 272'(probes1), 272'(e1.probes));
`endif
      end
    end
    if (done3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3_unexpected_done cycle=%0d required=no_done", cyc);
      end else begin
        e3 = q3.pop_front();
        check("dut3_done_cycle", 272'(cyc), 272'(e3.cyc));
        check("dut3_busy_at_done", 272'(busy3), 272'(0));
        check("dut3_found", 272'(found3), 272'(e3.found));
        check("dut3_result_addr", 272'(result_addr3), 272'(e3.addr));
        check("dut3_result_node", result_node3, e3.node);
`ifdef EXPLORED_LOOKUP_PROBES_EN
        check("dut3_probes", 272'(probes3), 272'(e3.probes));
`endif
      end
    end
  end

  task automatic go1(input logic [15:0] k);
    key1 = k; find1 = 1'b1;
    @(posedge clk); #1 find1 = 1'b0;
  endtask

  // dlat = done cycle relative to the cycle find is high.
  task automatic start1(input logic [15:0] k, input int dlat, input logic f,
                        input logic [6:0] a, input logic [271:0] n, input int pr);
    exp_t e;
    e.cyc = cyc + dlat; e.found = f; e.addr = a; e.node = n; e.probes = pr;
    q1.push_back(e);
    go1(k);
  endtask

  task automatic start3(input logic [15:0] k, input int dlat, input logic f,
                        input logic [6:0] a, input logic [271:0] n, input int pr);
    exp_t e;
    e.cyc = cyc + dlat; e.found = f; e.addr = a; e.node = n; e.probes = pr;
    q3.push_back(e);
    key3 = k; find3 = 1'b1;
    @(posedge clk); #1 find3 = 1'b0;
  endtask

  task automatic load_short1();
    for (int i = 0; i < 100; i++) ram1[i] = '0;
    ram1[0] = mkrec(16'd5, 0);
    ram1[1] = mkrec(16'd9, 1);
    ram1[2] = mkrec(16'd12, 2);
  endtask

  initial begin
    load_short1();
    for (int i = 0; i < 100; i++) ram3[i] = mkrec(16'd4, i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_addr", 272'(rd_addr1), 272'(0));
    check("reset_busy", 272'(busy1), 272'(0));
    check("reset_done", 272'(done1), 272'(0));
    check("reset_found", 272'(found1), 272'(0));
    check("reset_result_addr", 272'(result_addr1), 272'(0));
    check("reset_result_node", result_node1, 272'(0));
    check("reset_busy3", 272'(busy3), 272'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // ids 5,9,12,0: hit at address 1, then end-of-list at address 3.
    start1(16'd9, 4, 1'b1, 7'd1, mkrec(16'd9, 1), 2);
    check("busy_in_scan", 272'(busy1), 272'(1));
    repeat (6) @(posedge clk); #1;
    start1(16'd7, 6, 1'b0, 7'd3, 272'(0), 4);
    repeat (8) @(posedge clk); #1;

    // Fully populated RAM, absent key: full scan, never past address 99.
    for (int i = 0; i < 100; i++) ram1[i] = mkrec(16'(i + 1), i);
    max1 = 0;
    start1(16'd200, 102, 1'b0, 7'd0, 272'(0), 100);
    repeat (104) @(posedge clk); #1;
    check("scan_max_rd_addr", 272'(max1), 272'(99));

    // Latency 3, every id 4: first address wins, later returns discarded.
    start3(16'd4, 5, 1'b1, 7'd0, mkrec(16'd4, 0), 1);
    repeat (8) @(posedge clk); #1;
    // Free-slot search: key 0 hits the first empty address.
    ram3[3] = '0;
    start3(16'd0, 8, 1'b1, 7'd3, 272'(0), 4);
    repeat (10) @(posedge clk); #1;

    // Abort in cycle 2: idle in cycle 3, no done pulse, then a clean search.
    load_short1();
    go1(16'd9);
    @(posedge clk); #1;
    check("abort_busy_before", 272'(busy1), 272'(1));
    abort1 = 1'b1;
    @(posedge clk); #1 abort1 = 1'b0;
    check("abort_busy_after", 272'(busy1), 272'(0));
    check("abort_found", 272'(found1), 272'(0));
`ifdef EXPLORED_LOOKUP_PROBES_EN
    check("abort_probes", 272'(probes1), 272'(0));
`endif
    repeat (6) @(posedge clk); #1;
    start1(16'd9, 4, 1'b1, 7'd1, mkrec(16'd9, 1), 2);
    repeat (6) @(posedge clk); #1;

    // Async reset mid-scan clears outputs within the same cycle.
    go1(16'd9);
    @(posedge clk); #1;
    check("pre_reset_rd_addr", 272'(rd_addr1), 272'(1));
    #2 rst = 1'b1;
    #1;
    check("midreset_busy", 272'(busy1), 272'(0));
    check("midreset_rd_addr", 272'(rd_addr1), 272'(0));
    check("midreset_done", 272'(done1), 272'(0));
    check("midreset_found", 272'(found1), 272'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // find held high while busy and through the done cycle must be ignored.
    start1(16'd9, 4, 1'b1, 7'd1, mkrec(16'd9, 1), 2);
    key1 = 16'd12; find1 = 1'b1;
    repeat (4) @(posedge clk);
    #1 find1 = 1'b0;
    repeat (8) @(posedge clk); #1;

    check("q1_drained", 272'(q1.size()), 272'(0));
    check("q3_drained", 272'(q3.size()), 272'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
